// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM-side port between a read-only fetch port (F) and a read/write data port (D).
// Optional ISSUE-phase timeout abort is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              grant,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              pick;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`else
  logic              unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    pick        = grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          // On a tie the port that did not own the last transaction wins.
          pick      = (f_req && d_req) ? ~grant_q : d_req;
          grant_d   = pick;
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
          if (pick) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = f_addr;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end

      S_ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
          if (grant_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            f_ack_d   = 1'b1;
            f_rdata_d = mem_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mem_req_d = 1'b0;
            state_d   = S_RESP;
            err_d     = 1'b1;
            if (grant_q) begin
              d_ack_d   = 1'b1;
              d_rdata_d = DATA_W'(16'hDEAD);
            end else begin
              f_ack_d   = 1'b1;
              f_rdata_d = DATA_W'(16'hDEAD);
            end
          end
        end
`endif
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
